matrix_mem_responder: RTL and testbench
=======================================

# matrix_mem_responder

Memory-side responder for the matrix processor's read/write port. Serves the processor's read requests (matrix cache loads and work-item data) and accepts its result writes, sharing one single-port synchronous SRAM between them. Writes are absorbed into a small in-order write buffer and drained when the SRAM port is free, and reads are forwarded from that buffer so they always observe the newest value. Sits between `matrixProcessor` and the backing vertex/matrix SRAM.

## Interface
- `WIDTH`, 32, data width of processor port and SRAM.
- `ADDR_W`, 10, SRAM word-address width; processor addresses are truncated to the low `ADDR_W` bits.
- `DEPTH`, 4, write-buffer entries; must be a power of two, 2..16.

- `clk` in 1 — single clock, all logic on rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `rd_req` in 1 — read request, sampled with `rd_addr`.
- `rd_addr` in WIDTH — read word address.
- `rd_stall` out 1 — request not accepted this cycle; hold `rd_req`/`rd_addr`.
- `rd_valid` out 1 — one-cycle pulse, `rd_data` valid.
- `rd_data` out WIDTH — read result.
- `wr_en` in 1 — write request with `wr_addr`/`wr_data`.
- `wr_addr` in WIDTH — write word address.
- `wr_data` in WIDTH — write data.
- `wr_full` out 1 — write buffer full; `wr_en` ignored.
- `flush` in 1 — request full drain of the write buffer.
- `flush_done` out 1 — one-cycle pulse when a flush completes.
- `overflow` out 1 — sticky; set when `wr_en` arrives while `wr_full`.
- `mem_addr` out ADDR_W — SRAM address.
- `mem_we` out 1 — SRAM write strobe.
- `mem_wdata` out WIDTH — SRAM write data.
- `mem_rdata` in WIDTH — SRAM read data, valid the cycle after the address is presented.

## Operation
- The write buffer is a FIFO of {addr, data}, and `count` runs 0..DEPTH. `wr_full` = (`count`==DEPTH).
- SRAM arbitration is evaluated each cycle, with these priorities:
  1. State FLUSH, or `count`==DEPTH: drain the head entry. Set `mem_we`=1, `mem_addr`/`mem_wdata` = head, and pop. `rd_stall`=`rd_req`.
  2. Otherwise, if `rd_req`: accept the read, with `mem_addr`=`rd_addr[ADDR_W-1:0]` and `mem_we`=0. `rd_stall`=0.
  3. Otherwise, if `count`>0: drain the head as in 1.
  4. Otherwise idle, with `mem_we`=0.
- Writes are accepted when `wr_en` && !`wr_full`, including in the same cycle as a pop. Count update is +1 for push, −1 for pop, and 0 for both.
- Forwarding happens on read accept.
  - The address is compared against all valid buffer entries plus an incoming write accepted the same cycle.
  - The youngest match wins, and the same-cycle write is the youngest.
  - On a hit, its data is latched as the result. On a miss, `mem_rdata` is used next cycle.
- State machine:
  - RUN → FLUSH on `flush`.
  - FLUSH → DONE when `count`==0 and no push is occurring.
  - DONE → RUN unconditionally. `flush_done`=1 in DONE only.
  - A `flush` asserted while in FLUSH or DONE is ignored.
- In FLUSH, new writes are still accepted and extend the flush.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `flush_done`=0, `overflow`=0, `count`=0, state RUN. While `rst` is high, `mem_we`=0 and `rd_stall`=0.
- Read latency:
  - A read accepted in cycle N gives `rd_valid`=1 and `rd_data` in cycle N+2 (registered output), for both hit and miss.
  - Back-to-back reads sustain one per cycle.
- `rd_stall`, `wr_full`, `mem_addr`, `mem_we`, `mem_wdata` are combinational from state, `count` and `rd_req`. They have no path from `rd_data`.
- Reset mid-operation:
  - In-flight reads produce no `rd_valid`.
  - The buffer is discarded and its writes are lost.
  - The state returns to RUN.
- `overflow` clears only on `rst`.

## Test plan
- **Write then read, forwarded:** write A=0x10/D=0xDEAD at cycle 0, `rd_req` A=0x10 at cycle 1 → `rd_valid` at cycle 3 with 0xDEAD, and `mem_we` not yet asserted for 0x10.
- **Same-cycle write+read:** `wr_en` A=5/D=7 and `rd_req` A=5 in the same cycle, where the buffer already holds A=5/D=3 → `rd_data`=7.
- **Full buffer:** DEPTH writes with continuous `rd_req` → `wr_full`=1 and `rd_stall`=1 for exactly one cycle while the head drains. An extra `wr_en` while full sets `overflow`=1 and is otherwise dropped.
- **Idle drain order:** writes 1→0xA, 2→0xB, 1→0xC, then no reads → `mem_we` over 3 consecutive cycles with addresses 1, 2, 1 and data 0xA, 0xB, 0xC. A subsequent read of 1 returns 0xC via the SRAM path.
- **Flush:** 3 entries, then `flush` → reads stall, 3 drain cycles, then `flush_done` pulses exactly once 1 cycle after `count` reaches 0, and reads resume.
- **Reset mid-burst:** `rst` one cycle after a read accept with 2 buffered writes → no `rd_valid`, `count`=0, `mem_we`=0 during reset, and outputs at their reset values.

Source files
------------

// File: rtl/matrix_mem_responder.sv
// Memory-side responder for the matrix processor: single-port SRAM shared
// between reads and an in-order write buffer with read forwarding.
module matrix_mem_responder #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [WIDTH-1:0]  rd_addr,
    output logic              rd_stall,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_full,
    input  logic              flush,
    output logic              flush_done,
    output logic              overflow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] buf_addr_q [DEPTH];
    logic [WIDTH-1:0]  buf_data_q [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rd_pend_q, rd_pend_d;
    logic              fwd_hit_q, fwd_hit_d;
    logic [WIDTH-1:0]  fwd_data_q, fwd_data_d;
    logic              rd_valid_q;
    logic [WIDTH-1:0]  rd_data_q;
    logic              overflow_q, overflow_d;

    logic              full;
    logic              forced;
    logic              push;
    logic              pop;
    logic              rd_acc;
    logic [ADDR_W-1:0] rd_a;
    logic [ADDR_W-1:0] wr_a;
    logic              unused_addr_bits;

    assign rd_a = rd_addr[ADDR_W-1:0];
    assign wr_a = wr_addr[ADDR_W-1:0];
    assign unused_addr_bits = ^{rd_addr[WIDTH-1:ADDR_W], wr_addr[WIDTH-1:ADDR_W]};

    // Forced drain (flush or full buffer) outranks reads; otherwise reads win.
    always_comb begin
        full      = (count_q == FULL_CNT);
        forced    = (state_q == FLUSH) || full;
        push      = !rst && wr_en && !full;
        rd_acc    = !rst && rd_req && !forced;
        pop       = !rst && (count_q != '0) && (forced || !rd_req);
        rd_stall  = !rst && rd_req && forced;
        mem_we    = pop;
        mem_addr  = pop ? buf_addr_q[head_q] : rd_a;
        mem_wdata = buf_data_q[head_q];
        head_d    = pop ? head_q + PW'(1) : head_q;
        tail_d    = push ? tail_q + PW'(1) : tail_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        overflow_d = overflow_q | (wr_en & full);
    end

    // Scan oldest to youngest so the last match wins; the same-cycle write is youngest.
    always_comb begin
        fwd_hit_d  = 1'b0;
        fwd_data_d = '0;
        rd_pend_d  = rd_acc;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (buf_addr_q[head_q + PW'(i)] == rd_a)) begin
                fwd_hit_d  = 1'b1;
                fwd_data_d = buf_data_q[head_q + PW'(i)];
            end
        end
        if (push && (wr_a == rd_a)) begin
            fwd_hit_d  = 1'b1;
            fwd_data_d = wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (flush) state_d = FLUSH;
            FLUSH:   if ((count_q == '0) && !push) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rd_pend_q  <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rd_pend_q  <= rd_pend_d;
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
            rd_valid_q <= rd_pend_q;
            overflow_q <= overflow_d;
            if (rd_pend_q) begin
                rd_data_q <= fwd_hit_q ? fwd_data_q : mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[tail_q] <= wr_a;
            buf_data_q[tail_q] <= wr_data;
        end
    end

    assign wr_full    = full;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign flush_done = (state_q == DONE);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Randomized + directed bench for matrix_mem_responder against a
// sequential-memory reference model with an abstract write queue.
module tb_matrix_mem_responder;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_req;
    logic [WIDTH-1:0]  rd_addr;
    logic              rd_stall;
    logic              rd_valid;
    logic [WIDTH-1:0]  rd_data;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              wr_full;
    logic              flush;
    logic              flush_done;
    logic              overflow;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata = '0;

    matrix_mem_responder #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_stall(rd_stall),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full),
        .flush(flush), .flush_done(flush_done), .overflow(overflow),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] sram [1024];
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        mem_rdata <= sram[mem_addr];
    end

    int total = 0;
    int bad = 0;

    // Reference: what a plain memory would hold, plus the pending write queue.
    logic [WIDTH-1:0]  shadow [1024];
    logic [ADDR_W-1:0] qa [$];
    logic [WIDTH-1:0]  qd [$];
    int                mode = 0;
    logic              ov = 1'b0;
    logic              p1v = 1'b0, p2v = 1'b0;
    logic [WIDTH-1:0]  p1d = '0, p2d = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic rq, input logic [31:0] ra,
                        input logic we, input logic [31:0] wa, input logic [31:0] wd,
                        input logic fl);
        int n;
        logic full, forced, push, acc, e_we, e_stall;
        logic [WIDTH-1:0] e_rd;
        @(negedge clk);
        rst = r; rd_req = rq; rd_addr = ra;
        wr_en = we; wr_addr = wa; wr_data = wd; flush = fl;
        #1;
        n       = qa.size();
        full    = (n == DEPTH);
        forced  = (mode == 1) || full;
        e_we    = !r && (n > 0) && (forced || !rq);
        e_stall = !r && rq && forced;
        push    = !r && we && !full;
        acc     = !r && rq && !forced;
        check("wr_full", wr_full, full);
        check("rd_stall", rd_stall, e_stall);
        check("mem_we", mem_we, e_we);
        if (e_we) begin
            check("mem_addr_wr", mem_addr, qa[0]);
            check("mem_wdata", mem_wdata, qd[0]);
        end
        if (acc) check("mem_addr_rd", mem_addr, ra[ADDR_W-1:0]);
        check("rd_valid", rd_valid, p2v);
        if (p2v) check("rd_data", rd_data, p2d);
        check("flush_done", flush_done, mode == 2);
        check("overflow", overflow, ov);
        if (r) begin
            qa.delete(); qd.delete();
            mode = 0; ov = 1'b0; p1v = 1'b0; p2v = 1'b0;
            for (int a = 0; a < 1024; a++) shadow[a] = sram[a];
        end else begin
            if (we && full) ov = 1'b1;
            e_rd = (push && wa[ADDR_W-1:0] == ra[ADDR_W-1:0]) ? wd : shadow[ra[ADDR_W-1:0]];
            p2v = p1v; p2d = p1d;
            p1v = acc; p1d = e_rd;
            if (e_we) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (push) begin
                qa.push_back(wa[ADDR_W-1:0]);
                qd.push_back(wd);
                shadow[wa[ADDR_W-1:0]] = wd;
            end
            case (mode)
                0: if (fl) mode = 1;
                1: if (n == 0 && !push) mode = 2;
                default: mode = 0;
            endcase
        end
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] ra, wa;
        int wp;
        for (int a = 0; a < 1024; a++) begin
            sram[a] = '0;
            shadow[a] = '0;
        end
        rst = 1; rd_req = 1; rd_addr = 0; wr_en = 1; wr_addr = 3; wr_data = 9; flush = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rd_stall", rd_stall, 0);
        check("rst_wr_full", wr_full, 0);

        // write then forwarded read
        step(0, 0, 0, 1, 32'h10, 32'hDEAD, 0);
        step(0, 1, 32'h10, 0, 0, 0, 0);
        idle(6);
        // same-cycle write + read with an older match buffered
        step(0, 1, 32'h40, 1, 5, 3, 0);
        step(0, 1, 5, 1, 5, 7, 0);
        idle(6);
        // fill with continuous reads, then extra write while full
        for (int k = 0; k < DEPTH; k++) step(0, 1, 32'h20, 1, 32'h20 + k, 32'h100 + k, 0);
        step(0, 1, 32'h21, 1, 32'h77, 32'hBAD, 0);
        step(0, 1, 32'h22, 0, 0, 0, 0);
        idle(8);
        // idle drain order, then SRAM read-back
        step(0, 0, 0, 1, 1, 32'hA, 0);
        step(0, 0, 0, 1, 2, 32'hB, 0);
        step(0, 0, 0, 1, 1, 32'hC, 0);
        idle(5);
        step(0, 1, 1, 0, 0, 0, 0);
        idle(3);
        // flush with reads held
        for (int k = 0; k < 3; k++) step(0, 1, 32'h2, 1, 32'h30 + k, 32'h200 + k, 0);
        step(0, 1, 32'h31, 0, 0, 0, 1);
        for (int k = 0; k < 7; k++) step(0, 1, 32'h31, 0, 0, 0, 0);
        idle(3);
        // reset mid-burst
        step(0, 1, 32'h50, 1, 32'h51, 32'h1, 0);
        step(0, 1, 32'h52, 1, 32'h53, 32'h2, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(4);

        for (int c = 0; c < 3000; c++) begin
            wp = ((c / 400) % 2 == 1) ? 85 : 35;
            ra = $urandom; ra[ADDR_W-1:0] = 10'($urandom_range(0, 7));
            wa = $urandom; wa[ADDR_W-1:0] = 10'($urandom_range(0, 7));
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 99) < 55), ra,
                 ($urandom_range(0, 99) < wp), wa, $urandom,
                 ($urandom_range(0, 39) == 0));
        end

        step(0, 0, 0, 0, 0, 0, 1);
        idle(10);
        @(negedge clk);
        for (int a = 0; a < 8; a++) check("sram_final", sram[a], shadow[a]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
